tx_packetizer: RTL and testbench

Transmit-side framer that reads result words from the unified buffer and emits them as a byte stream into the TX FIFO for the UART. It is the counterpart of the controller's RX path, which assembles 16-bit words from byte pairs, low byte first. This block splits 16-bit words back into byte pairs, low byte first, and frames them as header, 16-bit length, payload. It sits between the controller (request side), the unified buffer (read port) and fifo_tx (write port).

---
 rtl/tx_packetizer.sv | 155 +++++++++++++++
 tb/tb_tx_packetizer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packetizer.sv
// tx_packetizer: frames buffer words as HEADER_BYTE, 16-bit length, payload (low byte first); TX_CHECKSUM_EN appends an XOR byte.
// Latency: 3 + 4*len cycles from request accept to the last byte (+1 with TX_CHECKSUM_EN), done one cycle later.
// Backpressure: fifo_full stalls the pending byte; state, fifo_wdata and counters hold until it clears.
module tx_packetizer #(
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int ADDRESS_SIZE     = 9,
    parameter int LEN_WIDTH        = 9,
    parameter logic [FIFO_DATA_WIDTH-1:0] HEADER_BYTE = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDRESS_SIZE-1:0]     req_addr,
    input  logic [LEN_WIDTH-1:0]        req_len,
    output logic                        buf_re,
    output logic [ADDRESS_SIZE-1:0]     buf_addr,
    input  logic [BUFFER_WORD_SIZE-1:0] buf_rdata,
    output logic                        fifo_we,
    output logic [FIFO_DATA_WIDTH-1:0]  fifo_wdata,
    input  logic                        fifo_full,
    output logic                        busy,
    output logic                        done
);
    localparam int W = FIFO_DATA_WIDTH;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_HDR    = 4'd1;
    localparam logic [3:0] S_LEN_LO = 4'd2;
    localparam logic [3:0] S_LEN_HI = 4'd3;
    localparam logic [3:0] S_RD     = 4'd4;
    localparam logic [3:0] S_WT     = 4'd5;
    localparam logic [3:0] S_LO     = 4'd6;
    localparam logic [3:0] S_HI     = 4'd7;
    localparam logic [3:0] S_FIN    = 4'd8;
`ifdef TX_CHECKSUM_EN
    localparam logic [3:0] S_CSUM   = 4'd9;
`endif

    logic [3:0]              state;
    logic [ADDRESS_SIZE-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [W-1:0]            hi_byte;
    logic [15:0]             len16;
    logic                    byte_pending;
    logic                    take;
    logic [3:0]              tail_state;
    logic [W-1:0]            tail_byte;

    assign len16 = 16'(len_q);

    always_comb begin
        byte_pending = 1'b0;
        case (state)
            S_HDR, S_LEN_LO, S_LEN_HI, S_LO, S_HI: byte_pending = 1'b1;
`ifdef TX_CHECKSUM_EN
            S_CSUM:                                byte_pending = 1'b1;
`endif
            default:                               byte_pending = 1'b0;
        endcase
    end

    // rst gates the strobes so a reset cycle can never push a byte or read a word
    assign fifo_we   = byte_pending && !fifo_full && !rst;
    assign take      = fifo_we;
    assign buf_re    = (state == S_RD) && !rst;
    assign buf_addr  = cur_addr;
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);

`ifdef TX_CHECKSUM_EN
    logic [W-1:0] csum;

    // accumulates every consumed byte after the header; the checksum byte itself is excluded
    always_ff @(posedge clk) begin
        if (rst)
            csum <= '0;
        else if (state == S_IDLE && req_valid)
            csum <= '0;
        else if (take && state != S_HDR && state != S_CSUM)
            csum <= csum ^ fifo_wdata;
    end

    assign tail_state = S_CSUM;
    assign tail_byte  = csum ^ fifo_wdata;
`else
    assign tail_state = S_FIN;
    assign tail_byte  = fifo_wdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            len_q      <= '0;
            remaining  <= '0;
            hi_byte    <= '0;
            fifo_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    cur_addr   <= req_addr;
                    len_q      <= req_len;
                    remaining  <= req_len;
                    fifo_wdata <= HEADER_BYTE;
                    state      <= S_HDR;
                end
                S_HDR: if (take) begin
                    fifo_wdata <= W'(len16[7:0]);
                    state      <= S_LEN_LO;
                end
                S_LEN_LO: if (take) begin
                    fifo_wdata <= W'(len16[15:8]);
                    state      <= S_LEN_HI;
                end
                S_LEN_HI: if (take) begin
                    if (len_q == '0) begin
                        fifo_wdata <= tail_byte;
                        state      <= tail_state;
                    end else begin
                        state      <= S_RD;
                    end
                end
                S_RD: state <= S_WT;
                S_WT: begin
                    fifo_wdata <= buf_rdata[W-1:0];
                    hi_byte    <= buf_rdata[2*W-1:W];
                    state      <= S_LO;
                end
                S_LO: if (take) begin
                    fifo_wdata <= hi_byte;
                    state      <= S_HI;
                end
                S_HI: if (take) begin
                    remaining <= remaining - LEN_WIDTH'(1);
                    cur_addr  <= cur_addr + ADDRESS_SIZE'(1);
                    if (remaining == LEN_WIDTH'(1)) begin
                        fifo_wdata <= tail_byte;
                        state      <= tail_state;
                    end else begin
                        state      <= S_RD;
                    end
                end
`ifdef TX_CHECKSUM_EN
                S_CSUM: if (take) state <= S_FIN;
`endif
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_packetizer.sv
// Scoreboard bench for tx_packetizer: stimulus pushes expected bytes/addresses, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_tx_packetizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_addr = '0;
    logic [8:0]  req_len = '0;
    logic        buf_re;
    logic [8:0]  buf_addr;
    logic [15:0] buf_rdata = '0;
    logic        fifo_we;
    logic [7:0]  fifo_wdata;
    logic        fifo_full = 1'b0;
    logic        busy;
    logic        done;

    tx_packetizer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .buf_re(buf_re), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
        .fifo_we(fifo_we), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:511];
    always @(posedge clk) if (buf_re) buf_rdata <= mem[buf_addr];

    logic [7:0] exp_bytes [$];
    logic [8:0] exp_addrs [$];
    int errors = 0, checks = 0;
    int wr_cnt = 0, re_cnt = 0, done_cnt = 0;
    int cyc = 0, t_acc = 0, t_done = 0;

`ifdef TX_CHECKSUM_EN
    localparam int CS_EXTRA = 1;
`else
    localparam int CS_EXTRA = 0;
`endif

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fifo_we) begin
            wr_cnt++;
            if (exp_bytes.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_byte: got %0h expected none", fifo_wdata);
            end else begin
                chk("byte", fifo_wdata, exp_bytes.pop_front());
            end
        end
        if (buf_re) begin
            re_cnt++;
            if (exp_addrs.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: got %0h expected none", buf_addr);
            end else begin
                chk("buf_addr", buf_addr, exp_addrs.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            t_done = cyc;
            chk("ready_low_at_done", req_ready, 0);
        end
    end

    task automatic expect_frame(input logic [8:0] addr, input int len);
        logic [7:0] b, cs;
        logic [8:0] a;
        logic [15:0] l16;
        cs = 8'h00; a = addr; l16 = 16'(len);
        exp_bytes.push_back(8'hA5);
        b = l16[7:0];  exp_bytes.push_back(b); cs ^= b;
        b = l16[15:8]; exp_bytes.push_back(b); cs ^= b;
        for (int i = 0; i < len; i++) begin
            exp_addrs.push_back(a);
            b = mem[a][7:0];  exp_bytes.push_back(b); cs ^= b;
            b = mem[a][15:8]; exp_bytes.push_back(b); cs ^= b;
            a = a + 9'd1;
        end
        if (CS_EXTRA == 1) exp_bytes.push_back(cs);
    endtask

    task automatic issue_req(input logic [8:0] addr, input int len);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = addr; req_len = 9'(len);
        @(negedge clk);
        chk("ready_at_req", req_ready, 1);
        @(posedge clk); #1;
        t_acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int d0, input int r0, input int nwords, input bit chk_lat);
        int n = 0;
        while (done_cnt == d0 && n < 400) begin @(posedge clk); n++; end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: got no done expected one", name);
        end else if (chk_lat) begin
            chk({name, "_latency"}, t_done - t_acc, 3 + 4 * nwords + CS_EXTRA);
        end
        repeat (3) @(negedge clk);
        chk({name, "_bytes_left"}, exp_bytes.size(), 0);
        chk({name, "_addrs_left"}, exp_addrs.size(), 0);
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_reads"}, re_cnt - r0, nwords);
        chk({name, "_ready_after"}, req_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0, r0, w0, n;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 16'h0101 + 16'h3C00);
        mem[9'h010] = 16'h1234; mem[9'h011] = 16'hABCD;
        mem[9'h1FF] = 16'h00FF; mem[9'h000] = 16'h0102;
        mem[9'h030] = 16'hBEEF;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_buf_re", buf_re, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_fifo_we", fifo_we, 0);
        chk("rst_fifo_wdata", fifo_wdata, 0);

        // basic two-word frame: A5 02 00 34 12 CD AB (+42)
        d0 = done_cnt; r0 = re_cnt;
        expect_frame(9'h010, 2);
        issue_req(9'h010, 2);
        finish_frame("basic", d0, r0, 2, 1'b1);

        // backpressure on the HI byte of word 0 (4 bytes already taken)
        d0 = done_cnt; r0 = re_cnt; w0 = wr_cnt;
        expect_frame(9'h010, 2);
        issue_req(9'h010, 2);
        n = 0;
        while (wr_cnt < w0 + 4 && n < 100) begin @(posedge clk); n++; end
        #1 fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_no_we", fifo_we, 0);
            chk("stall_hold_data", fifo_wdata, 8'h12);
            @(posedge clk);
        end
        #1 fifo_full = 1'b0;
        finish_frame("backpressure", d0, r0, 2, 1'b0);

        // address wrap: A5 02 00 FF 00 02 01 (+FE)
        d0 = done_cnt; r0 = re_cnt;
        expect_frame(9'h1FF, 2);
        issue_req(9'h1FF, 2);
        finish_frame("wrap", d0, r0, 2, 1'b1);

        // zero length: A5 00 00 (+00)
        d0 = done_cnt; r0 = re_cnt;
        expect_frame(9'h020, 0);
        issue_req(9'h020, 0);
        finish_frame("zero_len", d0, r0, 0, 1'b1);

        // reset after three bytes of a len=4 frame
        d0 = done_cnt; r0 = re_cnt; w0 = wr_cnt;
        exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h04); exp_bytes.push_back(8'h00);
        issue_req(9'h020, 4);
        n = 0;
        while (wr_cnt < w0 + 3 && n < 100) begin @(posedge clk); n++; end
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_re", buf_re, 0);
        chk("rst_mid_no_we", fifo_we, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wdata", fifo_wdata, 0);
        chk("rst_mid_addr", buf_addr, 0);
        repeat (6) @(negedge clk);
        chk("rst_mid_bytes", wr_cnt - w0, 3);
        chk("rst_mid_reads", re_cnt - r0, 0);
        chk("rst_mid_done", done_cnt - d0, 0);
        d0 = done_cnt; r0 = re_cnt;
        expect_frame(9'h030, 1);
        issue_req(9'h030, 1);
        finish_frame("after_rst", d0, r0, 1, 1'b1);

        // request while busy is ignored
        d0 = done_cnt; r0 = re_cnt;
        expect_frame(9'h010, 2);
        issue_req(9'h010, 2);
        repeat (3) @(posedge clk);
        #1 req_valid = 1'b1; req_addr = 9'h050; req_len = 9'd1;
        @(negedge clk);
        chk("busy_ready_low", req_ready, 0);
        chk("busy_high", busy, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        finish_frame("while_busy", d0, r0, 2, 1'b0);
        repeat (20) @(negedge clk);
        chk("while_busy_no_extra", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
